// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges EX and load writeback streams into a
// single registered write port with per-source hold buffers and round-robin grant.
module rf_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [IDX_W-1:0]      ex_rd,
    input  logic [XLEN-1:0]       ex_data,
    output logic                  ex_ready,
    input  logic                  ld_valid,
    input  logic [IDX_W-1:0]      ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    output logic                  rf_wen,
    output logic [IDX_W-1:0]      rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [2**IDX_W-1:0]   pend_mask,
    output logic [7:0]            conflict_cnt,
    output logic                  idle
);

    typedef enum logic {LAST_EX, LAST_LD} last_e;

    last_e              last_q, last_d;
    logic               ex_buf_v, ld_buf_v;
    logic [IDX_W-1:0]   ex_buf_rd, ld_buf_rd;
    logic [XLEN-1:0]    ex_buf_data, ld_buf_data;

    logic               ex_cand_v, ld_cand_v;
    logic [IDX_W-1:0]   ex_cand_rd, ld_cand_rd;
    logic [XLEN-1:0]    ex_cand_data, ld_cand_data;
    logic               ex_live, ld_live, same_rd;
    logic               grant_ex, grant_ld, drop_ld;

    assign ex_ready = ~ex_buf_v;
    assign ld_ready = ~ld_buf_v;
    assign idle     = ~ex_buf_v & ~ld_buf_v & ~rf_wen;

    // A full buffer always outranks the input, which keeps each source in order.
    assign ex_cand_v    = ex_buf_v | ex_valid;
    assign ex_cand_rd   = ex_buf_v ? ex_buf_rd : ex_rd;
    assign ex_cand_data = ex_buf_v ? ex_buf_data : ex_data;
    assign ld_cand_v    = ld_buf_v | ld_valid;
    assign ld_cand_rd   = ld_buf_v ? ld_buf_rd : ld_rd;
    assign ld_cand_data = ld_buf_v ? ld_buf_data : ld_data;

    assign ex_live = ex_cand_v && (ex_cand_rd != '0);
    assign ld_live = ld_cand_v && (ld_cand_rd != '0);
    assign same_rd = ex_live && ld_live && (ex_cand_rd == ld_cand_rd);

    always_comb begin
        grant_ex = 1'b0;
        grant_ld = 1'b0;
        drop_ld  = 1'b0;
        last_d   = last_q;
        if (same_rd) begin
            grant_ex = 1'b1;
            drop_ld  = 1'b1;
        end else if (ex_live && ld_live) begin
            if (last_q == LAST_LD) begin
                grant_ex = 1'b1;
                last_d   = LAST_EX;
            end else begin
                grant_ld = 1'b1;
                last_d   = LAST_LD;
            end
        end else begin
            grant_ex = ex_live;
            grant_ld = ld_live;
        end
    end

    always_comb begin
        pend_mask = '0;
        if (ex_buf_v) pend_mask[ex_buf_rd] = 1'b1;
        if (ld_buf_v) pend_mask[ld_buf_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            last_q       <= LAST_LD;
            ex_buf_v     <= 1'b0;
            ex_buf_rd    <= '0;
            ex_buf_data  <= '0;
            ld_buf_v     <= 1'b0;
            ld_buf_rd    <= '0;
            ld_buf_data  <= '0;
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            conflict_cnt <= '0;
        end else begin
            last_q <= last_d;
            rf_wen <= grant_ex | grant_ld;
            if (grant_ex) begin
                rf_waddr <= ex_cand_rd;
                rf_wdata <= ex_cand_data;
            end else if (grant_ld) begin
                rf_waddr <= ld_cand_rd;
                rf_wdata <= ld_cand_data;
            end

            if (ex_buf_v) begin
                if (grant_ex) ex_buf_v <= 1'b0;
            end else if (ex_live && !grant_ex) begin
                ex_buf_v    <= 1'b1;
                ex_buf_rd   <= ex_rd;
                ex_buf_data <= ex_data;
            end

            if (ld_buf_v) begin
                if (grant_ld || drop_ld) ld_buf_v <= 1'b0;
            end else if (ld_live && !grant_ld && !drop_ld) begin
                ld_buf_v    <= 1'b1;
                ld_buf_rd   <= ld_rd;
                ld_buf_data <= ld_data;
            end

            if (same_rd && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized self-checking bench for rf_wb_arbiter against a per-cycle
// reference model of the writeback rules, plus directed scenario checks.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ld_valid;
    logic [4:0]  ex_rd, ld_rd;
    logic [31:0] ex_data, ld_data;
    logic        ex_ready, ld_ready, rf_wen, idle;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pend_mask;
    logic [7:0]  conflict_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model: index 0 = EX, 1 = LD
    bit          m_v[2];
    logic [4:0]  m_rd[2];
    logic [31:0] m_d[2];
    int          m_last;       // source granted last in a contested cycle
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_cnt;

    rf_wb_arbiter #(.XLEN(32), .IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask), .conflict_cnt(conflict_cnt), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_step();
        bit          cv[2];
        logic [4:0]  crd[2];
        logic [31:0] cd[2];
        bit          live[2];
        int          win;
        bit          drop;
        if (rst_n) begin
            m_v[0] = 0; m_v[1] = 0; m_last = 1; m_wen = 0;
            m_waddr = '0; m_wdata = '0; m_cnt = 0;
            return;
        end
        cv[0]  = m_v[0] || ex_valid;  cv[1]  = m_v[1] || ld_valid;
        crd[0] = m_v[0] ? m_rd[0] : ex_rd;   crd[1] = m_v[1] ? m_rd[1] : ld_rd;
        cd[0]  = m_v[0] ? m_d[0]  : ex_data; cd[1]  = m_v[1] ? m_d[1]  : ld_data;
        for (int i = 0; i < 2; i++) live[i] = cv[i] && (crd[i] != 0);
        win = -1;
        drop = 0;
        if (live[0] && live[1] && crd[0] == crd[1]) begin
            win = 0; drop = 1;
            if (m_cnt < 255) m_cnt++;
        end else if (live[0] && live[1]) begin
            win = (m_last == 1) ? 0 : 1;
            m_last = win;
        end else if (live[0]) win = 0;
        else if (live[1]) win = 1;
        m_wen = (win >= 0);
        if (win >= 0) begin
            m_waddr = crd[win];
            m_wdata = cd[win];
        end
        for (int i = 0; i < 2; i++) begin
            if (i == win || (i == 1 && drop)) m_v[i] = 0;
            else if (live[i] && !m_v[i]) begin
                m_v[i] = 1; m_rd[i] = crd[i]; m_d[i] = cd[i];
            end
        end
    endtask

    task automatic cycle(input bit r, input bit ev, input int erd, input logic [31:0] ed,
                         input bit lv, input int lrd, input logic [31:0] ldd);
        logic [31:0] pm;
        rst_n = r; ex_valid = ev; ex_rd = 5'(erd); ex_data = ed;
        ld_valid = lv; ld_rd = 5'(lrd); ld_data = ldd;
        model_step();
        @(posedge clk);
        #1;
        pm = '0;
        for (int i = 0; i < 2; i++) if (m_v[i]) pm[m_rd[i]] = 1'b1;
        check("rf_wen",    64'(rf_wen),       64'(m_wen));
        check("rf_waddr",  64'(rf_waddr),     64'(m_waddr));
        check("rf_wdata",  64'(rf_wdata),     64'(m_wdata));
        check("ex_ready",  64'(ex_ready),     64'(!m_v[0]));
        check("ld_ready",  64'(ld_ready),     64'(!m_v[1]));
        check("pend_mask", 64'(pend_mask),    64'(pm));
        check("conflicts", 64'(conflict_cnt), 64'(m_cnt));
        check("idle",      64'(idle),         64'(!m_v[0] && !m_v[1] && !m_wen));
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic nop();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        ex_valid = 0; ld_valid = 0; ex_rd = '0; ld_rd = '0; ex_data = '0; ld_data = '0;
        rst_n = 1;
        do_reset();
        check("rst_ex_ready", 64'(ex_ready),  64'd1);
        check("rst_ld_ready", 64'(ld_ready),  64'd1);
        check("rst_idle",     64'(idle),      64'd1);
        check("rst_pend",     64'(pend_mask), 64'd0);

        // EX only
        cycle(0, 1, 5, 32'h11, 0, 0, 0);
        check("ex_only_wen",   64'(rf_wen),   64'd1);
        check("ex_only_addr",  64'(rf_waddr), 64'd5);
        check("ex_only_data",  64'(rf_wdata), 64'h11);
        check("ex_only_ready", 64'(ex_ready), 64'd1);

        // simultaneous, different rd
        do_reset();
        cycle(0, 1, 3, 32'hA, 1, 4, 32'hB);
        check("sim_c1_addr",  64'(rf_waddr),     64'd3);
        check("sim_c1_data",  64'(rf_wdata),     64'hA);
        check("sim_c1_ldrdy", 64'(ld_ready),     64'd0);
        check("sim_c1_pend4", 64'(pend_mask[4]), 64'd1);
        nop();
        check("sim_c2_wen",   64'(rf_wen),       64'd1);
        check("sim_c2_addr",  64'(rf_waddr),     64'd4);
        check("sim_c2_data",  64'(rf_wdata),     64'hB);
        nop();
        check("sim_c3_idle",  64'(idle),         64'd1);

        // same rd conflict
        do_reset();
        cycle(0, 1, 7, 32'h1, 1, 7, 32'h2);
        check("same_addr", 64'(rf_waddr),     64'd7);
        check("same_data", 64'(rf_wdata),     64'h1);
        check("same_cnt",  64'(conflict_cnt), 64'd1);
        nop();
        check("same_nowr", 64'(rf_wen),       64'd0);

        // x0 drop
        do_reset();
        cycle(0, 1, 0, 32'hFF, 1, 0, 32'hFF);
        check("x0_wen",   64'(rf_wen),   64'd0);
        check("x0_exrdy", 64'(ex_ready), 64'd1);
        check("x0_ldrdy", 64'(ld_ready), 64'd1);

        // saturation, then reset with the load buffer full
        do_reset();
        for (int i = 0; i < 300; i++) cycle(0, 1, 7, 32'(i), 1, 7, 32'(i + 1));
        check("sat_cnt", 64'(conflict_cnt), 64'd255);
        cycle(0, 1, 1, 32'h5, 1, 2, 32'h6);
        check("pre_rst_ldrdy", 64'(ld_ready), 64'd0);
        do_reset();
        check("rst_wen",   64'(rf_wen),       64'd0);
        check("rst_cnt",   64'(conflict_cnt), 64'd0);
        check("rst_addr",  64'(rf_waddr),     64'd0);
        check("rst_ldrdy", 64'(ld_ready),     64'd1);
        nop();
        check("post_rst_nowr", 64'(rf_wen), 64'd0);

        // random traffic with small rd range to provoke conflicts and x0
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 2),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter IDX_W, default 5, register index width; register count is 2**IDX_W.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, synchronous reset, asserted high.
REQ-006 SHALL have port ex_valid, input, 1, EX writeback request.
REQ-007 SHALL have port ex_rd, input, IDX_W, EX destination index.
REQ-008 SHALL have port ex_data, input, XLEN, EX result.
REQ-009 SHALL have port ex_ready, output, 1, EX request accepted when ex_valid & ex_ready.
REQ-010 SHALL have port ld_valid, input, 1, load writeback request.
REQ-011 SHALL have port ld_rd, input, IDX_W, load destination index.
REQ-012 SHALL have port ld_data, input, XLEN, load data.
REQ-013 SHALL have port ld_ready, output, 1, load request accepted when ld_valid & ld_ready.
REQ-014 SHALL have port rf_wen, output, 1, registered register-file write enable.
REQ-015 SHALL have port rf_waddr, output, IDX_W, registered write index.
REQ-016 SHALL have port rf_wdata, output, XLEN, registered write data.
REQ-017 SHALL have port pend_mask, output, 2**IDX_W, bit k set while a held entry targets register k.
REQ-018 SHALL have port conflict_cnt, output, 8, saturating count of superseded load writes.
REQ-019 SHALL have port idle, output, 1, both hold buffers empty and rf_wen low.

Function
REQ-020 SHALL keep one hold buffer (valid, rd, data) per source; ex_ready = ~ex_buf_valid, ld_ready = ~ld_buf_valid.
REQ-021 SHALL form each source's candidate from its buffer when full, else from the accepted input (bypass).
REQ-022 SHALL issue at most one write per cycle; winning candidate is loaded into rf_wen/rf_waddr/rf_wdata at the next edge (1-cycle latency).
REQ-023 SHALL arbitrate two candidates with different rd round-robin: a 1-bit last-grant pointer, reset to LD-last (EX first); the non-last source wins; the pointer updates to the winner.
REQ-024 SHALL capture a losing input candidate into its buffer; a losing buffered candidate stays in place.
REQ-025 SHALL, when both candidates have equal nonzero rd, grant EX (younger), discard the load candidate (clear its buffer if full), leave the pointer unchanged, increment conflict_cnt saturating at 255.
REQ-026 SHALL accept and silently drop any candidate with rd == 0: no write, no buffering, no arbitration.
REQ-027 SHALL bound grant latency: an accepted nonzero-rd request reaches rf_wen within 2 cycles of acceptance, unless superseded per REQ-025.
REQ-028 SHALL drive rf_wen low in any cycle with no valid nonzero-rd candidate; rf_waddr/rf_wdata hold their last value.
REQ-029 SHALL compute pend_mask combinationally as the OR of one-hot(rd) for each full buffer.
REQ-030 SHALL never reorder two writes from the same source.

Reset
REQ-031 SHALL, while rst_n is high at a clock edge, clear both buffers, rf_wen, rf_waddr, rf_wdata, conflict_cnt and set the pointer to LD-last.
REQ-032 SHALL hold ex_ready, ld_ready, idle high and pend_mask zero after reset.
REQ-033 SHALL discard in-flight requests when reset is asserted mid-operation; nothing is written after reset.

Verification
REQ-034 EX only: ex rd=5 data=0x11 -> next cycle rf_wen=1, waddr=5, wdata=0x11; ex_ready stays 1.
REQ-035 Simultaneous: ex rd=3/0xA, ld rd=4/0xB after reset -> cycle+1 write 3/0xA, ld_buf full, ld_ready=0, pend_mask bit4=1; cycle+2 write 4/0xB, idle=1 at cycle+3.
REQ-036 Same rd: ex rd=7/0x1, ld rd=7/0x2 -> only 7/0x1 written; conflict_cnt=1; no second write.
REQ-037 x0: ex rd=0 and ld rd=0 with data 0xFF -> rf_wen stays 0, both ready stay 1.
REQ-038 Saturation/reset: 300 same-rd conflicts -> conflict_cnt=255; assert rst_n with ld_buf full -> all outputs at reset values, no write.
